md_unit: RTL
============

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy-cycle count for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy-cycle count for div/divu.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  E-stage holds mult/multu/div/divu this cycle.
REQ-006 SHALL have port op  input  2  0=mult, 1=multu, 2=div, 3=divu; sampled only with start.
REQ-007 SHALL have port wr_hi  input  1  mthi in E-stage.
REQ-008 SHALL have port wr_lo  input  1  mtlo in E-stage.
REQ-009 SHALL have port A  input  32  forwarded rs operand.
REQ-010 SHALL have port B  input  32  forwarded rt operand.
REQ-011 SHALL have port busy  output  1  operation in flight; hazard unit stalls md instructions on it.
REQ-012 SHALL have port hi  output  32  architectural HI register.
REQ-013 SHALL have port lo  output  32  architectural LO register.

Function
REQ-014 SHALL implement two states, IDLE and BUSY, plus down-counter cnt (width fitting max(MULT_CYCLES,DIV_CYCLES)).
REQ-015 SHALL, in IDLE with start=1, latch the result into pending_hi/pending_lo, load cnt with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3), and enter BUSY.
REQ-016 SHALL drive busy=1 exactly while in BUSY: start sampled at edge of cycle t gives busy high cycles t+1..t+N, N = selected cycle count.
REQ-017 SHALL decrement cnt each BUSY cycle; on the edge with cnt=1, copy pending values into hi/lo and return to IDLE, so new hi/lo are visible in cycle t+N+1 and busy=0 there.
REQ-018 SHALL compute mult as signed 32x32->64 and multu as unsigned; HI = product[63:32], LO = product[31:0].
REQ-019 SHALL compute div/divu with LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-020 SHALL, on division with B=0, still run DIV_CYCLES busy cycles and leave hi/lo unchanged at completion.
REQ-021 SHALL, on signed div 0x80000000 / 0xFFFFFFFF, commit LO=0x80000000, HI=0.
REQ-022 SHALL ignore start while in BUSY (no restart, no counter reload); stalling such instructions is the hazard unit's job.
REQ-023 SHALL, in IDLE, write hi<=A on wr_hi and lo<=A on wr_lo at the same edge; both may be asserted together.
REQ-024 SHALL ignore wr_hi/wr_lo while in BUSY.
REQ-025 SHALL give start priority over wr_hi/wr_lo when asserted together in IDLE; the writes are dropped.
REQ-026 SHALL keep hi/lo outputs stable (old values) throughout BUSY.
REQ-027 SHALL treat MULT_CYCLES or DIV_CYCLES of 1 as a single busy cycle, commit at its end.

Reset
REQ-028 SHALL, with reset=1 at a clock edge, set state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending_hi=pending_lo=0.
REQ-029 SHALL, with reset mid-operation, abort the operation: no commit ever occurs, busy=0 next cycle.
REQ-030 SHALL give reset priority over start, wr_hi, wr_lo in the same cycle.

Verification
REQ-031 SHALL verify: start, op=0, A=0xFFFFFFFD, B=5 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-032 SHALL verify: start, op=1, A=0xFFFFFFFF, B=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-033 SHALL verify: start, op=2, A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 SHALL verify: hi=0x11, lo=0x22 preset via wr_hi/wr_lo; start, op=3, B=0 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
REQ-035 SHALL verify: during busy, pulse start (op=0, A=B=7) and wr_hi (A=0xAA) -> counter not reloaded, busy drops on schedule, hi/lo equal first operation's result only.
REQ-036 SHALL verify: reset asserted at busy cycle 3 of a mult -> next cycle busy=0, hi=lo=0, no later commit.

Source files
------------

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit -- multi-cycle multiply/divide unit with HI/LO registers.
//
// Holds the architectural HI/LO pair. A mult/multu/div/divu started in the
// E-stage computes its result immediately into a pending pair. The unit then
// reports busy for a fixed number of cycles and commits the pending pair to
// HI/LO when that count expires. mthi/mtlo write HI/LO directly while idle.
//
// Parameters
//   MULT_CYCLES : busy-cycle count for mult/multu (>= 1)
//   DIV_CYCLES  : busy-cycle count for div/divu   (>= 1)
//
// Ports
//   clk    in   1  clock; all state changes on the rising edge
//   reset  in   1  synchronous, active-high reset
//   start  in   1  launch the operation selected by op
//   op     in   2  0=mult 1=multu 2=div 3=divu (sampled with start)
//   wr_hi  in   1  mthi: HI <= A (idle only)
//   wr_lo  in   1  mtlo: LO <= A (idle only)
//   A      in  32  rs operand
//   B      in  32  rt operand
//   busy   out  1  operation in flight
//   hi     out 32  architectural HI
//   lo     out 32  architectural LO
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Two's-complement negation.
    function automatic logic [31:0] neg32(input logic [31:0] x);
        neg32 = ~x + 32'd1;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pending_hi;
    logic [31:0]      r_pending_lo;

    logic             w_busy_nxt;
    logic             w_load;
    logic             w_commit;
    logic             w_mt_hi;
    logic             w_mt_lo;
    logic [CNT_W-1:0] w_cnt_load;

    logic [63:0]      w_prod_s;
    logic [63:0]      w_prod_u;
    logic             w_signed_div;
    logic [31:0]      w_dvd;
    logic [31:0]      w_dvs;
    logic [31:0]      w_dvs_safe;
    logic [31:0]      w_uq;
    logic [31:0]      w_ur;
    logic [31:0]      w_quo;
    logic [31:0]      w_rem;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Arithmetic: products, magnitude division and result selection.
    always_comb begin
        // Low 64 bits of the sign-extended product equal the signed product.
        w_prod_s     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        w_prod_u     = {32'd0, A} * {32'd0, B};
        // Signed division runs on magnitudes; 0x80000000 / -1 then wraps to
        // quotient 0x80000000 with remainder 0, as required.
        w_signed_div = (op == 2'd2);
        w_dvd        = (w_signed_div && A[31]) ? neg32(A) : A;
        w_dvs        = (w_signed_div && B[31]) ? neg32(B) : B;
        w_dvs_safe   = (w_dvs == 32'd0) ? 32'd1 : w_dvs;
        w_uq         = w_dvd / w_dvs_safe;
        w_ur         = w_dvd % w_dvs_safe;
        w_quo        = (w_signed_div && (A[31] ^ B[31])) ? neg32(w_uq) : w_uq;
        w_rem        = (w_signed_div && A[31]) ? neg32(w_ur) : w_ur;
        w_res_hi     = r_hi;
        w_res_lo     = r_lo;
        case (op)
            2'd0: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            2'd1: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            2'd2, 2'd3: begin
                // Divide by zero re-commits the current HI/LO, i.e. no change.
                if (B == 32'd0) begin
                    w_res_hi = r_hi;
                    w_res_lo = r_lo;
                end else begin
                    w_res_hi = w_rem;
                    w_res_lo = w_quo;
                end
            end
            default: begin
                w_res_hi = r_hi;
                w_res_lo = r_lo;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_BUSY;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_BUSY;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode: controls for the datapath and the next busy value.
    always_comb begin
        w_busy_nxt = (w_state_nxt == S_BUSY);
        w_load     = 1'b0;
        w_commit   = 1'b0;
        w_mt_hi    = 1'b0;
        w_mt_lo    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // start wins over mthi/mtlo in the same cycle.
                w_load  = start;
                w_mt_hi = wr_hi & ~start;
                w_mt_lo = wr_lo & ~start;
            end
            S_BUSY: begin
                w_commit = (r_cnt <= CNT_ONE);
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
        if (op[1]) begin
            w_cnt_load = DIV_LOAD;
        end else begin
            w_cnt_load = MULT_LOAD;
        end
    end

    // Registered busy flag; mirrors the BUSY state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Counter, pending result and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_pending_hi <= 32'd0;
            r_pending_lo <= 32'd0;
            r_hi         <= 32'd0;
            r_lo         <= 32'd0;
        end else if (w_load) begin
            r_cnt        <= w_cnt_load;
            r_pending_hi <= w_res_hi;
            r_pending_lo <= w_res_lo;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - CNT_ONE;
            if (w_commit) begin
                r_hi <= r_pending_hi;
                r_lo <= r_pending_lo;
            end
        end else begin
            if (w_mt_hi) begin
                r_hi <= A;
            end
            if (w_mt_lo) begin
                r_lo <= A;
            end
        end
    end

endmodule
